// File: rtl/rv32_types_pkg.sv
// Shared RV32 core types: register ids, words, writeback source/load type
// encodings and the writeback-stage state enum.
package rv32_types;

    typedef logic [4:0]  rv_reg_id_t;
    typedef logic [31:0] rv32_word;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_PC4  = 2'd2,
        WB_LOAD = 2'd3
    } wb_src_t;

    // Encoded as the RV32 load funct3 so decode can pass it straight through.
    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b010,
        LT_LBU = 3'b100,
        LT_LHU = 3'b101
    } load_type_t;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        WAIT_LOAD = 2'd1,
        WB        = 2'd2
    } wb_stage_state_t;

    localparam rv32_word PC_STEP = 32'd4;

endpackage

// File: rtl/rv32_load_align.sv
// Purely combinational load data extraction: picks the byte/halfword/word
// addressed by addr[1:0], extends it, and flags misaligned accesses.
module rv32_load_align
    import rv32_types::*;
(
    input  rv32_word    rdata,
    input  logic [1:0]  addr,
    input  load_type_t  load_type,
    output rv32_word    value,
    output logic        misaligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{addr, 3'b000} +: 8];
        half_sel   = addr[1] ? rdata[31:16] : rdata[15:0];
        value      = rdata;
        misaligned = 1'b0;
        case (load_type)
            LT_LB:  value = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU: value = {24'd0, byte_sel};
            LT_LH: begin
                value      = {{16{half_sel[15]}}, half_sel};
                misaligned = addr[0];
            end
            LT_LHU: begin
                value      = {16'd0, half_sel};
                misaligned = addr[0];
            end
            LT_LW: begin
                value      = rdata;
                misaligned = (addr != 2'b00);
            end
            // Reserved funct3 codes behave as a word load.
            default: begin
                value      = rdata;
                misaligned = (addr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/rv32_writeback_stage.sv
// Final RV32 pipeline stage: retires one instruction per cycle into the
// register file, waiting on late load responses when needed.
//
//   state     | meaning
//   EMPTY     | nothing retiring, ready to accept
//   WAIT_LOAD | load accepted, waiting for dmem_rvalid; upstream stalled
//   WB        | held instruction is retiring this cycle, ready to accept
module rv32_writeback_stage
    import rv32_types::*;
#(
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  rv_reg_id_t           mem_rd,
    input  wb_src_t              mem_wb_src,
    input  load_type_t           mem_load_type,
    input  rv32_word             mem_result,
    input  logic [31:0]          mem_pc,
    input  logic                 dmem_rvalid,
    input  logic [31:0]          dmem_rdata,
    output logic                 rf_write,
    output logic [4:0]           rf_rw,
    output logic [31:0]          rf_d,
    output logic                 fwd_valid,
    output logic                 load_pending,
    output logic [4:0]           pending_rd,
    output logic                 load_misaligned,
    output logic [INSTRET_W-1:0] instret
);

    wb_stage_state_t        state, state_d;
    rv_reg_id_t             rd_q;
    rv32_word               data_q;
    wb_src_t                src_q;
    logic [31:0]            pc_q;
    load_type_t             lt_q;
    logic                   mis_q;
    logic [INSTRET_W-1:0]   instret_q;

    logic     accept;
    logic     retire;
    rv32_word align_value;
    logic     align_mis;

    // data_q holds the byte address until the load response replaces it.
    rv32_load_align u_align (
        .rdata      (dmem_rdata),
        .addr       (data_q[1:0]),
        .load_type  (lt_q),
        .value      (align_value),
        .misaligned (align_mis)
    );

    always_comb begin
        state_d   = state;
        mem_ready = (state != WAIT_LOAD);
        accept    = mem_valid && mem_ready;
        case (state)
            EMPTY: begin
                if (accept)
                    state_d = (mem_wb_src == WB_LOAD) ? WAIT_LOAD : WB;
            end
            WAIT_LOAD: begin
                if (dmem_rvalid)
                    state_d = WB;
            end
            WB: begin
                if (accept)
                    state_d = (mem_wb_src == WB_LOAD) ? WAIT_LOAD : WB;
                else
                    state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign retire = (state == WB) && !mis_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            rd_q      <= '0;
            data_q    <= '0;
            src_q     <= WB_NONE;
            pc_q      <= '0;
            lt_q      <= LT_LB;
            mis_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                rd_q   <= mem_rd;
                data_q <= mem_result;
                src_q  <= mem_wb_src;
                pc_q   <= mem_pc;
                lt_q   <= mem_load_type;
                mis_q  <= 1'b0;
            end else if ((state == WAIT_LOAD) && dmem_rvalid) begin
                data_q <= align_value;
                mis_q  <= align_mis;
            end
            if (retire)
                instret_q <= instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        rf_write        = (state == WB) && (src_q != WB_NONE) && (rd_q != 5'd0) && !mis_q;
        rf_rw           = rd_q;
        rf_d            = (src_q == WB_PC4) ? (pc_q + PC_STEP) : data_q;
        fwd_valid       = rf_write;
        load_pending    = (state == WAIT_LOAD);
        pending_rd      = rd_q;
        load_misaligned = (state == WB) && mis_q;
        instret         = instret_q;
    end

endmodule
